// File: rtl/bus85_mem.sv
// bus85_mem: core85 multiplexed-bus memory/IO slave with address window, wait states and ROM region
module bus85_mem #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 16,
  parameter int MEMSIZE = 12,
  parameter logic [ADDRSIZE-1:0] BASEADDR = '0,
  parameter int WAITSTATES = 0,
  parameter int ROMWORDS = 0,
  parameter int IOMODE = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ale,
  input  logic [DATASIZE-1:0]          adl,
  input  logic [ADDRSIZE-DATASIZE-1:0] adh,
  input  logic                         iom_,
  input  logic                         rd_,
  input  logic                         wr_,
  output logic [DATASIZE-1:0]          dout,
  output logic                         doe,
  output logic                         ready,
  output logic                         wprot
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA} st_t;
  localparam int unsigned WIN = 2 ** MEMSIZE;
  st_t st_q, st_d;
  logic [3:0] cnt_q, cnt_d;
  logic [ADDRSIZE-1:0] addr_q, addr_d;
  logic acc_wr_q, acc_wr_d, ready_q, ready_d, doe_q, doe_d, wprot_q, wprot_d;
  logic [DATASIZE-1:0] dout_q, dout_d;
  logic [DATASIZE-1:0] mem_q [WIN];
  logic [31:0] a_w, b_w;
  logic [MEMSIZE-1:0] off;
  logic sel, start, is_wr, enter, we;
  assign a_w = IOMODE != 0 ? 32'(addr_q[DATASIZE-1:0]) : 32'(addr_q);
  assign b_w = IOMODE != 0 ? 32'(BASEADDR[DATASIZE-1:0]) : 32'(BASEADDR);
  assign sel = (iom_ == (IOMODE != 0)) && a_w >= b_w && a_w < b_w + WIN;
  assign off = MEMSIZE'(a_w - b_w);
  assign start = sel && (rd_ ^ wr_);
  assign is_wr = st_q == S_IDLE ? !wr_ : acc_wr_q;
  assign enter = st_d == S_DATA && st_q != S_DATA;
  always_ff @(posedge clk)
    if (rst) begin
      st_q <= S_IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      acc_wr_q <= 1'b0;
      ready_q <= 1'b1;
      doe_q <= 1'b0;
      dout_q <= '0;
      wprot_q <= 1'b0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      acc_wr_q <= acc_wr_d;
      ready_q <= ready_d;
      doe_q <= doe_d;
      dout_q <= dout_d;
      wprot_q <= wprot_d;
    end
  always_comb begin
    st_d = st_q;
    if (rst) st_d = S_IDLE;
    else if (st_q == S_IDLE) st_d = start ? (WAITSTATES == 0 ? S_DATA : S_WAIT) : S_IDLE;
    else if (st_q == S_WAIT) st_d = (acc_wr_q ? wr_ : rd_) ? S_IDLE : (cnt_q == 0 ? S_DATA : S_WAIT);
    else st_d = rd_ && wr_ ? S_IDLE : S_DATA;
  end
  always_comb begin
    addr_d = st_q == S_IDLE && ale ? {adh, adl} : addr_q;
    acc_wr_d = is_wr;
    cnt_d = st_d != S_WAIT ? 4'd0 : (st_q == S_WAIT ? cnt_q - 4'd1 : 4'(WAITSTATES - 1));
    ready_d = st_d != S_WAIT;
    doe_d = st_d == S_DATA && !is_wr;
    dout_d = !doe_d ? '0 : (enter ? mem_q[off] : dout_q);
    wprot_d = enter && is_wr && int'(off) < ROMWORDS;
    we = enter && is_wr && int'(off) >= ROMWORDS;
  end
  always_ff @(posedge clk)
    if (we) mem_q[off] <= adl;
  assign dout = dout_q;
  assign doe = doe_q;
  assign ready = ready_q;
  assign wprot = wprot_q;
endmodule
